// File: rtl/led_bank_scheduler_if.sv
// Bus between the MCU/led_matrix banks and the bank scheduler.
//   Configuration : en, bank_mask, dead_time, timeout
//   Bank inputs   : bank_n_en, bank_m_en, bank_done_tick (packed per bank)
//   Pin outputs   : n_en (shared cathodes), m_en (gated anodes), grant,
//                   switch_tick, timeout_tick
// master = MCU/bank side, slave = scheduler.
interface led_bank_scheduler_if #(
  parameter int BANKS        = 2,
  parameter int LEDS_N       = 10,
  parameter int LEDS_M       = 3,
  parameter int DEAD_BITS    = 8,
  parameter int TIMEOUT_BITS = 16
);
  logic                      en;
  logic [BANKS-1:0]          bank_mask;
  logic [DEAD_BITS-1:0]      dead_time;
  logic [TIMEOUT_BITS-1:0]   timeout;
  logic [BANKS*LEDS_N-1:0]   bank_n_en;
  logic [BANKS*LEDS_M-1:0]   bank_m_en;
  logic [BANKS-1:0]          bank_done_tick;
  logic [LEDS_N-1:0]         n_en;
  logic [BANKS*LEDS_M-1:0]   m_en;
  logic [BANKS-1:0]          grant;
  logic                      switch_tick;
  logic                      timeout_tick;

  modport master (
    output en, bank_mask, dead_time, timeout, bank_n_en, bank_m_en, bank_done_tick,
    input  n_en, m_en, grant, switch_tick, timeout_tick
  );

  modport slave (
    input  en, bank_mask, dead_time, timeout, bank_n_en, bank_m_en, bank_done_tick,
    output n_en, m_en, grant, switch_tick, timeout_tick
  );
endinterface

// File: rtl/led_bank_scheduler.sv
// Time-multiplexes BANKS led_matrix banks onto one shared set of cathode lines.
// Round-robin grant among enabled banks; a grant ends on the bank's done_tick,
// on timeout, or when the bank is masked off. A programmable blanking gap is
// inserted between grants.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      led_bank_scheduler_if.slave (config, bank inputs, pin outputs)
module led_bank_scheduler #(
  parameter int BANKS        = 2,
  parameter int LEDS_N       = 10,
  parameter int LEDS_M       = 3,
  parameter int DEAD_BITS    = 8,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  led_bank_scheduler_if.slave bus
);

  localparam int IW = (BANKS > 1) ? $clog2(BANKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BLANK
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [TIMEOUT_BITS-1:0] drv_cnt_q, drv_cnt_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic [DEAD_BITS-1:0]    blank_q, blank_d;

  logic                    sel_valid;
  logic [IW-1:0]           sel_idx;
  logic                    switch_tick;
  logic                    timeout_tick;

  // First enabled bank at or after the next pointer, with wrap-around.
  always_comb begin
    int unsigned cand;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < BANKS; i++) begin
      cand = (32'(ptr_q) + i) % BANKS;
      if (!sel_valid && bus.bank_mask[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      drv_cnt_q <= '0;
      tmo_q     <= '0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      drv_cnt_q <= drv_cnt_d;
      tmo_q     <= tmo_d;
      blank_q   <= blank_d;
    end
  end

  always_comb begin
    logic done_hit;
    logic tmo_hit;
    logic mask_drop;
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    drv_cnt_d    = drv_cnt_q;
    tmo_d        = tmo_q;
    blank_d      = blank_q;
    switch_tick  = 1'b0;
    timeout_tick = 1'b0;
    done_hit     = bus.bank_done_tick[idx_q];
    tmo_hit      = (tmo_q != '0) && (drv_cnt_q == tmo_q - TIMEOUT_BITS'(1));
    mask_drop    = !bus.bank_mask[idx_q];

    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_d   = DRIVE;
            idx_d     = sel_idx;
            ptr_d     = (sel_idx == IW'(BANKS - 1)) ? '0 : sel_idx + IW'(1);
            drv_cnt_d = '0;
            tmo_d     = bus.timeout;
          end
        end
        DRIVE: begin
          if (drv_cnt_q != '1) drv_cnt_d = drv_cnt_q + TIMEOUT_BITS'(1);
          if (done_hit || tmo_hit || mask_drop) begin
            switch_tick  = 1'b1;
            // done_tick and mask removal both take precedence over timeout.
            timeout_tick = tmo_hit && !done_hit && !mask_drop;
            if (bus.dead_time != '0) begin
              state_d = BLANK;
              blank_d = bus.dead_time - DEAD_BITS'(1);
            end else if (sel_valid) begin
              state_d   = DRIVE;
              idx_d     = sel_idx;
              ptr_d     = (sel_idx == IW'(BANKS - 1)) ? '0 : sel_idx + IW'(1);
              drv_cnt_d = '0;
              tmo_d     = bus.timeout;
            end else begin
              state_d = IDLE;
            end
          end
        end
        BLANK: begin
          if (blank_q != '0) begin
            blank_d = blank_q - DEAD_BITS'(1);
          end else if (sel_valid) begin
            state_d   = DRIVE;
            idx_d     = sel_idx;
            ptr_d     = (sel_idx == IW'(BANKS - 1)) ? '0 : sel_idx + IW'(1);
            drv_cnt_d = '0;
            tmo_d     = bus.timeout;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pin decode is purely from registered state, so reset blanks outputs at once.
  always_comb begin
    bus.n_en  = '0;
    bus.m_en  = '0;
    bus.grant = '0;
    if (state_q == DRIVE) begin
      bus.n_en                            = bus.bank_n_en[32'(idx_q)*LEDS_N +: LEDS_N];
      bus.m_en[32'(idx_q)*LEDS_M +: LEDS_M] = bus.bank_m_en[32'(idx_q)*LEDS_M +: LEDS_M];
      bus.grant[idx_q]                    = 1'b1;
    end
  end

  assign bus.switch_tick  = switch_tick;
  assign bus.timeout_tick = timeout_tick;

endmodule

// File: tb/tb_led_bank_scheduler.sv
// Directed bench for led_bank_scheduler: reset, round-robin with blanking,
// pin muxing, timeout, done/timeout collision, single-bank operation,
// enable drop and asynchronous reset.
module tb_led_bank_scheduler;
  localparam int BANKS        = 2;
  localparam int LEDS_N       = 10;
  localparam int LEDS_M       = 3;
  localparam int DEAD_BITS    = 8;
  localparam int TIMEOUT_BITS = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  led_bank_scheduler_if #(
    .BANKS(BANKS), .LEDS_N(LEDS_N), .LEDS_M(LEDS_M),
    .DEAD_BITS(DEAD_BITS), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) bus ();

  led_bank_scheduler #(
    .BANKS(BANKS), .LEDS_N(LEDS_N), .LEDS_M(LEDS_M),
    .DEAD_BITS(DEAD_BITS), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pins(input string tag, input logic [1:0] g, input logic [9:0] n,
                          input logic [5:0] m);
    chk({tag, "_grant"}, 32'(bus.grant), 32'(g));
    chk({tag, "_n_en"},  32'(bus.n_en),  32'(n));
    chk({tag, "_m_en"},  32'(bus.m_en),  32'(m));
  endtask

  initial begin
    logic [1:0] expg;
    reset_n            = 1'b0;
    bus.en             = 1'b0;
    bus.bank_mask      = '0;
    bus.dead_time      = '0;
    bus.timeout        = '0;
    bus.bank_n_en      = {10'h2AA, 10'h155};
    bus.bank_m_en      = {3'b110, 3'b011};
    bus.bank_done_tick = '0;

    // Reset state
    repeat (3) step();
    chk_pins("reset", 2'b00, 10'h000, 6'b000000);
    chk("reset_switch", 32'(bus.switch_tick), 32'd0);
    chk("reset_timeout", 32'(bus.timeout_tick), 32'd0);

    // Round robin with 3-cycle blanking
    bus.en        = 1'b1;
    bus.bank_mask = 2'b11;
    bus.dead_time = 8'd3;
    bus.timeout   = 16'd0;
    step();
    chk("held_in_reset", 32'(bus.grant), 32'd0);
    reset_n = 1'b1;
    step();
    chk_pins("drive0", 2'b01, 10'h155, 6'b000011);
    repeat (5) step();
    chk_pins("drive0_hold", 2'b01, 10'h155, 6'b000011);

    bus.bank_done_tick = 2'b01;
    #1;
    chk("done0_switch", 32'(bus.switch_tick), 32'd1);
    chk("done0_no_timeout", 32'(bus.timeout_tick), 32'd0);
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk_pins("blank1", 2'b00, 10'h000, 6'b000000);
    chk("blank1_switch", 32'(bus.switch_tick), 32'd0);
    step();
    chk("blank2_grant", 32'(bus.grant), 32'd0);
    step();
    chk_pins("blank3", 2'b00, 10'h000, 6'b000000);
    step();
    chk_pins("drive1", 2'b10, 10'h2AA, 6'b110000);

    // done_tick of a non-granted bank is ignored
    bus.bank_done_tick = 2'b01;
    #1;
    chk("foreign_done_switch", 32'(bus.switch_tick), 32'd0);
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("foreign_done_grant", 32'(bus.grant), 32'd2);

    // Timeout captured at entry: current grant keeps timeout disabled
    bus.dead_time = 8'd0;
    bus.timeout   = 16'd100;
    repeat (120) step();
    chk("tmo_sampled_at_entry", 32'(bus.grant), 32'd2);

    bus.bank_done_tick = 2'b10;
    #1;
    chk("done1_switch", 32'(bus.switch_tick), 32'd1);
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk_pins("dead0_direct", 2'b01, 10'h155, 6'b000011);

    // Four timeout-ended grants, 100 DRIVE cycles each
    for (int g = 0; g < 4; g++) begin
      expg = (g % 2 == 1) ? 2'b10 : 2'b01;
      chk("tmo_grant", 32'(bus.grant), 32'(expg));
      repeat (98) step();
      chk("tmo_cycle99_switch", 32'(bus.switch_tick), 32'd0);
      chk("tmo_cycle99_tick", 32'(bus.timeout_tick), 32'd0);
      step();
      chk("tmo_cycle100_tick", 32'(bus.timeout_tick), 32'd1);
      chk("tmo_cycle100_switch", 32'(bus.switch_tick), 32'd1);
      step();
    end
    chk("tmo_after_loop", 32'(bus.grant), 32'd1);

    // done and timeout on the same cycle
    repeat (99) step();
    bus.bank_done_tick = 2'b01;
    #1;
    chk("collide_switch", 32'(bus.switch_tick), 32'd1);
    chk("collide_timeout", 32'(bus.timeout_tick), 32'd0);
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("collide_next", 32'(bus.grant), 32'd2);

    // Single enabled bank, no blanking
    bus.bank_mask = 2'b10;
    bus.timeout   = 16'd0;
    bus.bank_done_tick = 2'b10;
    #1;
    chk("single_switch", 32'(bus.switch_tick), 32'd1);
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("single_regrant", 32'(bus.grant), 32'd2);
    repeat (3) step();
    bus.bank_done_tick = 2'b10;
    #1;
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("single_regrant2", 32'(bus.grant), 32'd2);

    // Mask removal mid-DRIVE
    bus.bank_mask = 2'b00;
    #1;
    chk("unmask_switch", 32'(bus.switch_tick), 32'd1);
    chk("unmask_no_timeout", 32'(bus.timeout_tick), 32'd0);
    step();
    chk_pins("unmask_idle", 2'b00, 10'h000, 6'b000000);
    bus.bank_done_tick = 2'b01;
    #1;
    chk("idle_done_switch", 32'(bus.switch_tick), 32'd0);
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("idle_done_grant", 32'(bus.grant), 32'd0);

    // Enable drop keeps the pointer
    bus.bank_mask = 2'b11;
    bus.dead_time = 8'd2;
    step();
    chk("resume_grant", 32'(bus.grant), 32'd1);
    repeat (2) step();
    bus.en = 1'b0;
    #1;
    chk("en_drop_switch", 32'(bus.switch_tick), 32'd0);
    step();
    chk_pins("en_drop", 2'b00, 10'h000, 6'b000000);
    bus.en = 1'b1;
    step();
    chk("ptr_kept", 32'(bus.grant), 32'd2);

    // Reset mid-BLANK, pointer returns to bank 0
    bus.bank_done_tick = 2'b10;
    #1;
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("blank_d2_1", 32'(bus.grant), 32'd0);
    step();
    step();
    chk("after_blank_d2", 32'(bus.grant), 32'd1);
    bus.bank_done_tick = 2'b01;
    #1;
    step();
    bus.bank_done_tick = 2'b00;
    #1;
    chk("blank_before_reset", 32'(bus.grant), 32'd0);
    reset_n = 1'b0;
    #1;
    chk_pins("reset_mid_blank", 2'b00, 10'h000, 6'b000000);
    chk("reset_mid_blank_switch", 32'(bus.switch_tick), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk_pins("post_reset_first", 2'b01, 10'h155, 6'b000011);

    // Asynchronous reset mid-DRIVE, away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk_pins("async_reset_drive", 2'b00, 10'h000, 6'b000000);
    chk("async_reset_switch", 32'(bus.switch_tick), 32'd0);
    chk("async_reset_timeout", 32'(bus.timeout_tick), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
